// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction
// memory and registers each fetched word with its PC into a valid/ready slot.
module fetch_unit #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [15:0] if_count,
  output logic        dbg_state
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_fault_pc, w_fault_pc_nxt;
  logic [15:0] r_count, w_count_nxt;

  logic w_consumed;
  logic w_can_load;
  logic w_oob;

  // Slot handshake: a slot transfers on every edge where if_valid and if_ready
  // are both high; while if_valid is high and if_ready low, if_pc/if_instr hold.
  assign w_consumed = r_valid & if_ready;
  assign w_can_load = (~r_valid | if_ready) & ~stall;
  assign w_oob      = ({2'b00, r_pc[31:2]} >= DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_fault_pc <= 32'h0;
      r_count    <= 16'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_fault_pc <= w_fault_pc_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_fault_pc_nxt = r_fault_pc;
    w_count_nxt    = r_count + 16'(w_consumed);
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect flushes the slot even when decode is stalled.
          w_valid_nxt = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            w_state_nxt    = S_FAULT;
            w_fault_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = redirect_pc;
          end
        end else if (w_can_load && w_oob) begin
          w_state_nxt    = S_FAULT;
          w_fault_pc_nxt = r_pc;
          w_valid_nxt    = 1'b0;
        end else if (w_can_load) begin
          w_if_instr_nxt = imem_instr;
          w_if_pc_nxt    = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + 32'd4;
        end else if (w_consumed) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_FAULT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_FAULT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_addr = r_pc[9:2];
  assign if_valid  = r_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign fault     = (r_state == S_FAULT);
  assign fault_pc  = r_fault_pc;
  assign if_count  = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps, random traffic and a long
// accept run, all checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [15:0] if_count;
  logic        dbg_state;

  logic [31:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  // model of the stage as seen by decode
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_slot_pc;
  logic [31:0] m_slot_instr;
  logic        m_fault;
  logic [31:0] m_fault_pc;
  int          m_accepts;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .fault(fault), .fault_pc(fault_pc), .if_count(if_count), .dbg_state(dbg_state)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit rv,
                            input logic [31:0] rpc, input bit rdy);
    bit accepted;
    bit loadable;
    accepted = m_valid && rdy;
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_slot_pc = 0; m_slot_instr = 0;
      m_fault = 0; m_fault_pc = 0; m_accepts = 0;
      return;
    end
    if (accepted) m_accepts++;
    if (m_fault) return;
    loadable = (!m_valid || rdy) && !st;
    if (rv) begin
      m_valid = 0;
      if (rpc % 4 != 0) begin
        m_fault = 1; m_fault_pc = rpc;
      end else begin
        m_pc = rpc;
      end
    end else if (loadable && (m_pc / 4) >= DEPTH) begin
      m_fault = 1; m_fault_pc = m_pc; m_valid = 0;
    end else if (loadable) begin
      m_slot_pc = m_pc;
      m_slot_instr = mem[m_pc / 4];
      m_valid = 1;
      m_pc = m_pc + 4;
    end else if (accepted) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_pc", if_pc, m_slot_pc);
    chk("if_instr", if_instr, m_slot_instr);
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("dbg_state", {31'b0, dbg_state}, {31'b0, m_fault});
    chk("fault_pc", fault_pc, m_fault_pc);
    chk("if_count", {16'b0, if_count}, 32'(m_accepts % 65536));
    chk("imem_addr", {24'b0, imem_addr}, {24'b0, m_pc[9:2]});
  endtask

  task automatic cyc(input bit rst, input bit st, input bit rv,
                     input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
    model_edge(rst, st, rv, rpc, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; if_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_7033; mem[1] = 32'h0010_0093; mem[2] = 32'h0020_0113;

    // reset then three accepting cycles
    cyc(1, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_count", {16'b0, if_count}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("tp1_pc0", if_pc, 32'h0);
    chk("tp1_in0", if_instr, 32'h0000_7033);
    cyc(0, 0, 0, 0, 1);
    chk("tp1_pc1", if_pc, 32'h4);
    chk("tp1_in1", if_instr, 32'h0010_0093);
    cyc(0, 0, 0, 0, 1);
    chk("tp1_pc2", if_pc, 32'h8);
    chk("tp1_in2", if_instr, 32'h0020_0113);

    // backpressure: slot held, pc parked at 4
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk("bp_pc", if_pc, 32'h0);
    chk("bp_instr", if_instr, 32'h0000_7033);
    chk("bp_addr", {24'b0, imem_addr}, 32'h1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_next_pc", if_pc, 32'h4);
    chk("bp_next_in", if_instr, 32'h0010_0093);

    // redirect under stall flushes, target one edge later
    cyc(0, 1, 1, 32'h28, 0);
    chk("rd_bubble", {31'b0, if_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("rd_pc", if_pc, 32'h28);
    chk("rd_instr", if_instr, mem[10]);

    // misaligned redirect traps, later redirects ignored, reset clears
    cyc(0, 0, 1, 32'h2A, 1);
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_fpc", fault_pc, 32'h2A);
    cyc(0, 0, 1, 32'h40, 1);
    cyc(0, 0, 0, 0, 1);
    chk("mis_held", fault_pc, 32'h2A);
    cyc(1, 0, 0, 0, 1);
    chk("mis_rst", {31'b0, fault}, 32'h0);
    chk("mis_rst_addr", {24'b0, imem_addr}, 32'h0);

    // sequential run off the end of memory
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 1);
    chk("oob_last_pc", if_pc, 32'hFC);
    cyc(0, 0, 0, 0, 1);
    chk("oob_fault", {31'b0, fault}, 32'h1);
    chk("oob_fpc", fault_pc, 32'h100);
    chk("oob_valid", {31'b0, if_valid}, 32'h0);

    // reset mid-stream with a valid slot
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("mid_valid", {31'b0, if_valid}, 32'h0);
    chk("mid_pc", if_pc, 32'h0);
    chk("mid_instr", if_instr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, st, rv, rdy;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = 32'($urandom_range(0, 70)) * 4;
      if ($urandom_range(0, 19) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      cyc(rst, st, rv, rpc, rdy);
    end

    // long accept run until the counter wraps
    cyc(1, 0, 0, 0, 1);
    begin
      int k;
      k = 0;
      while (m_accepts < 65540 && k < 75000) begin
        cyc(0, 0, (k % 50) == 49, 32'h0, 1);
        k++;
      end
      chk("wrap_reached", {31'b0, m_accepts >= 65540}, 32'h1);
      chk("wrap_count", {16'b0, if_count}, 32'(m_accepts - 65536));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
